vscale_htif_pcr_responder: RTL
==============================

# vscale_htif_pcr_responder

Target-side responder for the HTIF PCR request/response channel. It accepts host read/write requests, services the `tohost` and `fromhost` registers, and returns one response per request. It sits between the off-chip host (or testbench host model) and the core's CSR file. The core deposits `tohost` values and consumes `fromhost` values through a separate core-side port.

## Interface
Parameters:
- `PCR_WIDTH`, 64: data width of requests, responses and both registers.
- `ADDR_WIDTH`, 12: CSR address width.
- `TOHOST_ADDR`, 12'h780: address of `tohost`.
- `FROMHOST_ADDR`, 12'h781: address of `fromhost`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `htif_pcr_req_valid` in 1: host request valid.
- `htif_pcr_req_ready` out 1: responder can accept a request.
- `htif_pcr_req_rw` in 1: 1 = write, 0 = read.
- `htif_pcr_req_addr` in ADDR_WIDTH: target CSR address.
- `htif_pcr_req_data` in PCR_WIDTH: write data.
- `htif_pcr_resp_valid` out 1: response valid.
- `htif_pcr_resp_ready` in 1: host accepts response.
- `htif_pcr_resp_data` out PCR_WIDTH: response data.
- `core_tohost_wen` in 1: core writes `tohost`.
- `core_tohost_wdata` in PCR_WIDTH: core `tohost` data.
- `core_tohost_ready` out 1: `tohost` is empty (zero), so a core write is accepted.
- `core_fromhost_rdata` out PCR_WIDTH: current `fromhost` value.
- `core_fromhost_clr` in 1: core clears `fromhost` after consuming it.

## Operation
- Two-state FSM:
  - IDLE: `htif_pcr_req_ready`=1 and `htif_pcr_resp_valid`=0.
  - RESP: `htif_pcr_req_ready`=0 and `htif_pcr_resp_valid`=1.
- IDLE→RESP on `req_valid`. The request is accepted, the response data is latched and side effects are applied in that cycle.
- RESP→IDLE on `resp_ready`. RESP holds indefinitely with `resp_data` stable while `resp_ready`=0.
- Read of `TOHOST_ADDR`:
  - Response = current `tohost`.
  - `tohost` is cleared to 0 at accept (read-to-clear).
- Read of `FROMHOST_ADDR`: response = current `fromhost`; no side effect.
- Write to either register:
  - Response = the register's previous value (swap semantics).
  - The register takes `req_data` at accept.
- Unmapped address:
  - Read returns 0; write is ignored and returns 0.
  - A response is always produced.
- Core `tohost` write: `core_tohost_ready` = (`tohost`==0). The write takes effect only when `core_tohost_wen && core_tohost_ready`. When not ready, the write is dropped; the core must hold and retry.
- `core_fromhost_rdata` is a direct view of the `fromhost` register.
- `core_fromhost_clr` zeroes `fromhost` next edge.
- Simultaneous events, same cycle, resolved in this priority order:
  - Host write to `tohost` vs. core `tohost` write: host wins.
  - Host read of `tohost` while `tohost`==0 vs. core write: response 0; `tohost` ends as the core data. No clear is applied, because the clear is a no-op on 0.
  - Host write to `fromhost` vs. `core_fromhost_clr`: host write wins.
- Reset (active-low, synchronous, `reset`=0 at the edge):
  - FSM→IDLE; `tohost`=0; `fromhost`=0; response data register=0.
  - Outputs after reset: `req_ready`=1, `resp_valid`=0, `resp_data`=0, `core_tohost_ready`=1, `core_fromhost_rdata`=0.
  - Reset asserted while in RESP discards the pending response. The host must not expect it.

## Timing
- Request accepted on edge N, response valid from N+1.
- A response handshaking on edge M makes `req_ready` high at M+1. Throughput is at most one request per 2 cycles.
- Register side effects are visible one cycle after accept, e.g. a core read of `fromhost` at N+1 sees the host write.
- `core_tohost_ready` is registered-state-derived and has no combinational path from the host ports.
- Drop-on-clear: a `tohost` value is destroyed at the accept edge, so it must be considered delivered at that edge even if `resp_ready` stalls.

## Test plan
- Reset then idle: hold `reset`=0 for 3 edges, then release → `req_ready`=1, `resp_valid`=0, `core_tohost_ready`=1, `core_fromhost_rdata`=0.
- Core writes 144 to `tohost`; host polls reads of 12'h780 with `req_valid` held 1 and `resp_ready`=1:
  - Polls before the core write → responses are 0.
  - First poll after the write → 144.
  - Following poll → 0; `core_tohost_ready` returns to 1 one cycle after accept.
- Host writes 64'h5 to 12'h781 → response 0 at N+1; `core_fromhost_rdata`=5. Then `core_fromhost_clr` pulse → `core_fromhost_rdata`=0 next cycle.
- Backpressure: read of `tohost`=7 with `resp_ready`=0 for 4 cycles → `resp_valid` held 1 and `resp_data`=7 stable. `req_ready`=0 throughout. `tohost` already 0; a core write of 9 during the stall is accepted.
- Core write of 3 with `tohost`=1 (not ready) → dropped; `tohost` stays 1. Same-cycle host write 11 to `tohost` plus core write 22 with `tohost`=0 → `tohost`=11.
- Unmapped address 12'h123 read and write → response 0; both registers unchanged. Reset asserted during RESP → `resp_valid`=0 next cycle.

Source files
------------

// File: rtl/vscale_htif_pcr_responder.sv
// HTIF PCR target-side responder: services host reads/writes of tohost and
// fromhost, returns one response per request, and exposes a core-side port.
//
// Handshake: a request transfers on an edge where htif_pcr_req_valid and
// htif_pcr_req_ready are both 1; a response transfers on an edge where
// htif_pcr_resp_valid and htif_pcr_resp_ready are both 1. Once asserted, the
// response stays valid with stable data until it transfers.
module vscale_htif_pcr_responder #(
    parameter int                    PCR_WIDTH     = 64,
    parameter int                    ADDR_WIDTH    = 12,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR   = 12'h780,
    parameter logic [ADDR_WIDTH-1:0] FROMHOST_ADDR = 12'h781
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  htif_pcr_req_valid,
    output logic                  htif_pcr_req_ready,
    input  logic                  htif_pcr_req_rw,
    input  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
    input  logic [PCR_WIDTH-1:0]  htif_pcr_req_data,
    output logic                  htif_pcr_resp_valid,
    input  logic                  htif_pcr_resp_ready,
    output logic [PCR_WIDTH-1:0]  htif_pcr_resp_data,
    input  logic                  core_tohost_wen,
    input  logic [PCR_WIDTH-1:0]  core_tohost_wdata,
    output logic                  core_tohost_ready,
    output logic [PCR_WIDTH-1:0]  core_fromhost_rdata,
    input  logic                  core_fromhost_clr,
    output logic                  debug_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [PCR_WIDTH-1:0] tohost, tohost_next;
    logic [PCR_WIDTH-1:0] fromhost, fromhost_next;
    logic [PCR_WIDTH-1:0] resp_data, resp_data_next;
    logic                 accept;
    logic                 hit_tohost;
    logic                 hit_fromhost;

    assign hit_tohost   = (htif_pcr_req_addr == TOHOST_ADDR);
    assign hit_fromhost = (htif_pcr_req_addr == FROMHOST_ADDR);

    // State, registers and latched response data; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tohost    <= '0;
            fromhost  <= '0;
            resp_data <= '0;
        end else begin
            state     <= state_next;
            tohost    <= tohost_next;
            fromhost  <= fromhost_next;
            resp_data <= resp_data_next;
        end
    end

    // Next-state, register side effects and handshake outputs.
    always_comb begin
        state_next          = state;
        tohost_next         = tohost;
        fromhost_next       = fromhost;
        resp_data_next      = resp_data;
        htif_pcr_req_ready  = 1'b0;
        htif_pcr_resp_valid = 1'b0;
        accept              = 1'b0;

        case (state)
            IDLE: begin
                htif_pcr_req_ready = 1'b1;
                accept             = htif_pcr_req_valid;
                if (htif_pcr_req_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                htif_pcr_resp_valid = 1'b1;
                if (htif_pcr_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Response is always the register's value before this request;
        // unmapped addresses answer 0.
        if (accept) begin
            if (hit_tohost) begin
                resp_data_next = tohost;
            end else if (hit_fromhost) begin
                resp_data_next = fromhost;
            end else begin
                resp_data_next = '0;
            end
        end

        // tohost: host write beats core write; a host read clears it. The core
        // can only write while tohost is zero, so a clear never races a core
        // write that would be lost.
        if (accept && hit_tohost && htif_pcr_req_rw) begin
            tohost_next = htif_pcr_req_data;
        end else if (accept && hit_tohost && (tohost != '0)) begin
            tohost_next = '0;
        end else if (core_tohost_wen && core_tohost_ready) begin
            tohost_next = core_tohost_wdata;
        end

        // fromhost: host write beats the core's clear.
        if (accept && hit_fromhost && htif_pcr_req_rw) begin
            fromhost_next = htif_pcr_req_data;
        end else if (core_fromhost_clr) begin
            fromhost_next = '0;
        end
    end

    assign core_tohost_ready   = (tohost == '0);
    assign core_fromhost_rdata = fromhost;
    assign htif_pcr_resp_data  = resp_data;
    assign debug_state         = state;

endmodule
